// File: rtl/pc_sequencer.sv
// Program-counter sequencer: drives an external 4-bit counter through FETCH/DECODE/EXEC rounds.
// Strobes are combinational decodes of state and inputs; done is a registered one-cycle end pulse.
module pc_sequencer #(
    parameter logic [3:0] START_ADDR = 4'h0,
    parameter logic [3:0] LAST_ADDR  = 4'hF,
    parameter bit         WRAP       = 1'b0
) (
    input  logic       clock,
    input  logic       rst,
    input  logic       start,
    input  logic       halt,
    input  logic       jump_req,
    input  logic [3:0] jump_addr,
    input  logic       stall,
    input  logic [3:0] pc_in,
    output logic [3:0] ctr_in,
    output logic       ctr_load,
    output logic       ctr_inc,
    output logic       fetch_en,
    output logic       ir_load,
    output logic       busy,
    output logic       done,
    output logic       halted,
    output logic [7:0] instr_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_HALTED
    } state_t;

    state_t     state_q, state_d;
    logic       done_q, done_d;
    logic [7:0] count_q, count_d;
    logic [7:0] count_next;

    assign count_next = (count_q == 8'hFF) ? count_q : count_q + 8'd1;

    always_ff @(posedge clock) begin
        if (rst) begin
            state_q <= S_IDLE;
            done_q  <= 1'b0;
            count_q <= 8'h00;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        done_d   = 1'b0;
        count_d  = count_q;
        ctr_in   = 4'h0;
        ctr_load = 1'b0;
        ctr_inc  = 1'b0;
        fetch_en = 1'b0;
        ir_load  = 1'b0;
        // Reset must also suppress strobes so the external counter is not disturbed.
        if (!rst) begin
            case (state_q)
                S_IDLE, S_HALTED: begin
                    if (start) begin
                        ctr_load = 1'b1;
                        ctr_in   = START_ADDR;
                        count_d  = 8'h00;
                        state_d  = S_FETCH;
                    end
                end
                S_FETCH: begin
                    fetch_en = 1'b1;
                    if (!stall) begin
                        state_d = S_DECODE;
                    end
                end
                S_DECODE: begin
                    ir_load = 1'b1;
                    state_d = S_EXEC;
                end
                S_EXEC: begin
                    if (halt) begin
                        state_d = S_HALTED;
                    end else if (jump_req) begin
                        ctr_load = 1'b1;
                        ctr_in   = jump_addr;
                        count_d  = count_next;
                        state_d  = S_FETCH;
                    end else if (pc_in == LAST_ADDR && !WRAP) begin
                        done_d  = 1'b1;
                        count_d = count_next;
                        state_d = S_IDLE;
                    end else begin
                        ctr_inc = 1'b1;
                        count_d = count_next;
                        state_d = S_FETCH;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign busy        = (state_q == S_FETCH) || (state_q == S_DECODE) || (state_q == S_EXEC);
    assign halted      = (state_q == S_HALTED);
    assign done        = done_q;
    assign instr_count = count_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: default instance plus a WRAP=1 instance, each with its own counter.
module tb_pc_sequencer;

    logic       clock = 1'b0;
    always #5 clock = ~clock;

    logic       rst, start, halt, jump_req, stall;
    logic [3:0] jump_addr;
    logic [3:0] pc0, pc1;

    logic [3:0] ctr_in0, ctr_in1;
    logic       ctr_load0, ctr_inc0, fetch_en0, ir_load0, busy0, done0, halted0;
    logic       ctr_load1, ctr_inc1, fetch_en1, ir_load1, busy1, done1, halted1;
    logic [7:0] instr_count0, instr_count1;
    logic [18:0] outs0, outs1;

    assign outs0 = {ctr_in0, ctr_load0, ctr_inc0, fetch_en0, ir_load0, busy0, done0, halted0, instr_count0};
    assign outs1 = {ctr_in1, ctr_load1, ctr_inc1, fetch_en1, ir_load1, busy1, done1, halted1, instr_count1};

    int vectors = 0;
    int miscompares = 0;
    int dn0 = 0;
    int dn1 = 0;

    pc_sequencer dut0 (
        .clock(clock), .rst(rst), .start(start), .halt(halt), .jump_req(jump_req),
        .jump_addr(jump_addr), .stall(stall), .pc_in(pc0), .ctr_in(ctr_in0),
        .ctr_load(ctr_load0), .ctr_inc(ctr_inc0), .fetch_en(fetch_en0), .ir_load(ir_load0),
        .busy(busy0), .done(done0), .halted(halted0), .instr_count(instr_count0)
    );

    pc_sequencer #(.WRAP(1'b1)) dut1 (
        .clock(clock), .rst(rst), .start(start), .halt(halt), .jump_req(jump_req),
        .jump_addr(jump_addr), .stall(stall), .pc_in(pc1), .ctr_in(ctr_in1),
        .ctr_load(ctr_load1), .ctr_inc(ctr_inc1), .fetch_en(fetch_en1), .ir_load(ir_load1),
        .busy(busy1), .done(done1), .halted(halted1), .instr_count(instr_count1)
    );

    // External counters driven by the sequencer strobes.
    always @(posedge clock) begin
        if (ctr_load0) pc0 <= ctr_in0;
        else if (ctr_inc0) pc0 <= pc0 + 4'h1;
        if (ctr_load1) pc1 <= ctr_in1;
        else if (ctr_inc1) pc1 <= pc1 + 4'h1;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
        if (done0) dn0++;
        if (done1) dn1++;
    endtask

    // One FETCH(+stalls)/DECODE/EXEC round on dut0; exp_exec = {ctr_load, ctr_inc, ctr_in}.
    task automatic round(input int stalls, input logic h, input logic j, input logic [3:0] ja,
                         input logic [5:0] exp_exec, input string tag);
        stall = 1'b1;
        for (int s = 0; s < stalls; s++) begin
            #1 chk({tag, "_stall"}, 32'({fetch_en0, ctr_load0, ctr_inc0, busy0}), 32'(4'b1001));
            step();
        end
        stall = 1'b0;
        #1 chk({tag, "_fetch"}, 32'({fetch_en0, ir_load0, ctr_load0, ctr_inc0}), 32'(4'b1000));
        step();
        #1 chk({tag, "_decode"}, 32'({ir_load0, fetch_en0, ctr_load0, ctr_inc0}), 32'(4'b1000));
        step();
        halt = h; jump_req = j; jump_addr = ja;
        #1 chk({tag, "_exec"}, 32'({ctr_load0, ctr_inc0, ctr_in0}), 32'(exp_exec));
        step();
        halt = 1'b0; jump_req = 1'b0; jump_addr = 4'h0;
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; halt = 1'b0; jump_req = 1'b0; stall = 1'b0;
        jump_addr = 4'h0; pc0 = 4'h9; pc1 = 4'h9;
        step(); step();
        rst = 1'b0;
        #1 chk("reset_outs0", 32'(outs0), 32'h0);
        chk("reset_outs1", 32'(outs1), 32'h0);
        chk("reset_no_ctr_clear", 32'(pc0), 32'h9);
        step();
        #1 chk("idle_hold", 32'(outs0), 32'h0);

        // Straight run from 0 to F.
        start = 1'b1;
        #1 chk("start_load", 32'({ctr_load0, ctr_inc0, ctr_in0}), 32'(6'h20));
        step(); start = 1'b0; dn0 = 0;
        for (int i = 0; i < 16; i++)
            round(0, 1'b0, 1'b0, 4'h0, (i < 15) ? 6'h10 : 6'h00, "straight");
        #1 chk("straight_done_busy", 32'({done0, busy0}), 32'(2'b10));
        chk("straight_count", 32'(instr_count0), 32'h10);
        step();
        #1 chk("straight_done_pulse", 32'(done0), 32'h0);
        chk("straight_done_once", 32'(dn0), 32'd1);

        // Three stall cycles on the first fetch.
        do_start(); dn0 = 0;
        for (int i = 0; i < 16; i++)
            round((i == 0) ? 3 : 0, 1'b0, 1'b0, 4'h0, (i < 15) ? 6'h10 : 6'h00, "stall_run");
        #1 chk("stall_count", 32'(instr_count0), 32'h10);
        chk("stall_done", 32'(done0), 32'h1);

        // Jump at LAST_ADDR wins over program end.
        step();
        do_start(); dn0 = 0;
        for (int i = 0; i < 15; i++)
            round(0, 1'b0, 1'b0, 4'h0, 6'h10, "pre_jump");
        chk("jump_at_last_pc", 32'(pc0), 32'hF);
        round(0, 1'b0, 1'b1, 4'h3, 6'h23, "jump_last");
        #1 chk("jump_target", 32'(pc0), 32'h3);
        chk("jump_no_done", 32'(dn0), 32'd0);
        for (int i = 0; i < 13; i++)
            round(0, 1'b0, 1'b0, 4'h0, (i < 12) ? 6'h10 : 6'h00, "post_jump");
        #1 chk("jump_count", 32'(instr_count0), 32'h1D);
        chk("jump_done_once", 32'(dn0), 32'd1);

        // Halt and jump in the same EXEC cycle: halt wins.
        step();
        do_start();
        round(0, 1'b0, 1'b0, 4'h0, 6'h10, "pre_halt");
        round(0, 1'b0, 1'b0, 4'h0, 6'h10, "pre_halt");
        round(0, 1'b1, 1'b1, 4'h5, 6'h00, "halt_jump");
        #1 chk("halt_state", 32'({halted0, busy0, instr_count0}), 32'({2'b10, 8'h02}));
        chk("halt_pc_kept", 32'(pc0), 32'h2);
        jump_req = 1'b1; jump_addr = 4'h7;
        #1 chk("halted_ignores_jump", 32'({ctr_load0, ctr_inc0, ctr_in0}), 32'(6'h00));
        step();
        jump_req = 1'b0; jump_addr = 4'h0;
        #1 chk("halted_hold", 32'(halted0), 32'h1);
        start = 1'b1;
        #1 chk("restart_load", 32'({ctr_load0, ctr_in0}), 32'(5'h10));
        step(); start = 1'b0;
        #1 chk("restart_state", 32'({halted0, busy0, instr_count0}), 32'({2'b01, 8'h00}));
        chk("restart_pc", 32'(pc0), 32'h0);

        // Reset during EXEC with a pending jump.
        round(0, 1'b0, 1'b0, 4'h0, 6'h10, "pre_rst");
        chk("pre_rst_count", 32'(instr_count0), 32'h01);
        step(); step();
        jump_req = 1'b1; jump_addr = 4'h7; rst = 1'b1;
        #1 chk("rst_exec_no_load", 32'({ctr_load0, ctr_inc0}), 32'h0);
        step();
        rst = 1'b0; jump_req = 1'b0; jump_addr = 4'h0;
        #1 chk("rst_exec_outs", 32'(outs0), 32'h0);
        chk("rst_exec_pc", 32'(pc0), 32'h1);

        // WRAP instance: 300 instructions, count saturates, no done.
        do_start(); dn1 = 0;
        for (int c = 0; c < 900; c++) begin
            #1;
            if (c == 47)
                chk("wrap_inc_at_last", 32'({pc1, ctr_inc1, ctr_load1}), 32'(6'b1111_10));
            step();
        end
        #1 chk("wrap_saturate", 32'(instr_count1), 32'hFF);
        chk("wrap_no_done", 32'(dn1), 32'd0);
        chk("wrap_busy", 32'(busy1), 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter START_ADDR, default 4'h0, address loaded into the program counter on start.
REQ-002 Parameter LAST_ADDR, default 4'hF, final program address.
REQ-003 Parameter WRAP, default 0: 0 = stop after LAST_ADDR; 1 = wrap to 4'h0 and continue.
REQ-004 clock  in  1  sole clock, rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 start  in  1  run request, level-sampled in IDLE/HALTED only.
REQ-007 halt  in  1  stop request, sampled in EXEC only.
REQ-008 jump_req  in  1  branch request, sampled in EXEC only.
REQ-009 jump_addr  in  4  branch target.
REQ-010 stall  in  1  memory not ready, sampled in FETCH only.
REQ-011 pc_in  in  4  current value of the external 4-bit counter.
REQ-012 ctr_in  out  4  load value for the counter.
REQ-013 ctr_load  out  1  counter load strobe.
REQ-014 ctr_inc  out  1  counter increment strobe.
REQ-015 fetch_en  out  1  memory read strobe.
REQ-016 ir_load  out  1  instruction register load strobe.
REQ-017 busy  out  1  high in FETCH, DECODE and EXEC.
REQ-018 done  out  1  one-cycle pulse on normal program end.
REQ-019 halted  out  1  high in HALTED.
REQ-020 instr_count  out  8  executed-instruction count.

Function
REQ-021 States: IDLE, FETCH, DECODE, EXEC, HALTED; the state register is the only state-holding element apart from instr_count and done.
REQ-022 Strobes (ctr_load, ctr_inc, ctr_in, fetch_en, ir_load) are combinational decodes of the current state and inputs; the counter updates on the same edge as the state transition.
REQ-023 ctr_load and ctr_inc are never both 1; ctr_in is 4'h0 whenever ctr_load is 0.
REQ-024 IDLE or HALTED with start=1: ctr_load=1, ctr_in=START_ADDR, instr_count cleared, next state FETCH; with start=0 the state holds and all strobes are 0.
REQ-025 FETCH: fetch_en=1; with stall=1 the state holds FETCH (fetch_en stays 1, no counter strobe); with stall=0 the next state is DECODE.
REQ-026 DECODE: ir_load=1 for exactly one cycle; the next state is EXEC.
REQ-027 EXEC priority is halt > jump_req > end-of-program > increment.
REQ-028 EXEC with halt=1: no counter strobe, next state HALTED, instr_count unchanged.
REQ-029 EXEC with jump_req=1, halt=0: ctr_load=1, ctr_in=jump_addr, next state FETCH; this applies even when pc_in==LAST_ADDR.
REQ-030 EXEC with pc_in==LAST_ADDR and WRAP=0 (no halt/jump): no counter strobe; done=1 in the following cycle; next state IDLE.
REQ-031 EXEC with pc_in==LAST_ADDR and WRAP=1: ctr_inc=1 (counter wraps 4'hF->4'h0), next state FETCH, no done pulse.
REQ-032 EXEC otherwise: ctr_inc=1, next state FETCH.
REQ-033 instr_count increments by 1 on each EXEC exit other than halt; it saturates at 8'hFF and holds its value in IDLE/HALTED until the next start.
REQ-034 done is registered and set for exactly one cycle; busy and halted are decodes of the state register.
REQ-035 start, halt and jump_req in states where they are not sampled have no effect.

Reset
REQ-036 rst=1 at a rising edge forces IDLE, done=0 and instr_count=8'h00; rst overrides all other inputs, including mid-FETCH/EXEC.
REQ-037 While the state is IDLE after reset, all outputs are 0 until start.
REQ-038 The sequencer does not clear the external counter on reset; the counter is initialised only by the start load.

Verification
REQ-039 Straight run (defaults, stall=0): start pulse -> ctr_load with ctr_in=0; 16 FETCH/DECODE/EXEC rounds (48 cycles); done pulses once; instr_count=8'h10; busy=0.
REQ-040 Stall: 3 stall cycles in FETCH -> fetch_en held 4 cycles, no ctr_inc, then DECODE; the program completes with the same count.
REQ-041 Jump at LAST_ADDR: pc_in=4'hF with jump_req=1, jump_addr=4'h3 -> ctr_load=1, ctr_in=3, no done pulse, next fetch from 3.
REQ-042 Halt+jump same EXEC cycle -> no strobe, halted=1, instr_count unchanged; start afterwards -> reload 0, halted=0.
REQ-043 WRAP=1 at pc_in=4'hF -> ctr_inc=1, no done pulse; 300 instructions -> instr_count=8'hFF.
REQ-044 rst asserted during EXEC with jump_req=1 -> IDLE next cycle, all outputs 0, no ctr_load.
